// File: rtl/lock_seq_pkg.sv
// Shared encodings for the lock sequencer: FSM states, trigger modes, counter widths.
package lock_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_LOCKED = 2'b10,
    ST_LOST   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    TM_MANUAL     = 2'b00,
    TM_TIME       = 2'b01,
    TM_LEVEL      = 2'b10,
    TM_TIME_LEVEL = 2'b11
  } trig_mode_e;

  localparam int unsigned LOSS_W   = 16;
  localparam int unsigned RELOCK_W = 8;

endpackage : lock_seq_pkg

// File: rtl/lock_sequencer_if.sv
// Control/status bundle of the lock sequencer; master drives controls, slave is the sequencer.
interface lock_sequencer_if #(
  parameter int unsigned DW   = 14,
  parameter int unsigned NPID = 2,
  parameter int unsigned TW   = 32
);
  logic                 arm;
  logic                 lock_now;
  logic [1:0]           trig_mode;
  logic                 rising;
  logic [TW-1:0]        time_th;
  logic signed [DW-1:0] level_th;
  logic signed [DW-1:0] loss_lo;
  logic signed [DW-1:0] loss_hi;
  logic [15:0]          loss_cycles;
  logic [NPID:0]        idle_en;
  logic [NPID:0]        lock_en;
  logic signed [DW-1:0] signal;
  logic                 ramp_trig;
  logic                 ramp_enable;
  logic [NPID-1:0]      pid_enable;
  logic                 lock_trig;
  logic                 locked;
  logic                 lock_lost;
  logic [1:0]           state;
  logic [7:0]           relock_cnt;

  modport master (
    output arm, lock_now, trig_mode, rising, time_th, level_th, loss_lo, loss_hi,
           loss_cycles, idle_en, lock_en, signal, ramp_trig,
    input  ramp_enable, pid_enable, lock_trig, locked, lock_lost, state, relock_cnt
  );

  modport slave (
    input  arm, lock_now, trig_mode, rising, time_th, level_th, loss_lo, loss_hi,
           loss_cycles, idle_en, lock_en, signal, ramp_trig,
    output ramp_enable, pid_enable, lock_trig, locked, lock_lost, state, relock_cnt
  );
endinterface : lock_sequencer_if

// File: rtl/lock_trig_det.sv
// Signal pipeline, ramp-synchronous time counter and trigger decode.
module lock_trig_det
  import lock_seq_pkg::*;
#(
  parameter int unsigned DW = 14,
  parameter int unsigned TW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] signal,
  input  logic                 ramp_trig,
  input  logic [1:0]           trig_mode,
  input  logic                 rising,
  input  logic [TW-1:0]        time_th,
  input  logic signed [DW-1:0] level_th,
  output logic signed [DW-1:0] s_now,
  output logic                 trig_c
);

  logic signed [DW-1:0] s_now_q, s_now_d;
  logic signed [DW-1:0] s_last_q, s_last_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic                 level_evt_c;

  // Next values: two-stage signal history, counter restarts after ramp start.
  always_comb begin
    s_now_d  = signal;
    s_last_d = s_now_q;
    cnt_d    = ramp_trig ? '0 : cnt_q + TW'(1);
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_now_q  <= '0;
      s_last_q <= '0;
      cnt_q    <= '0;
    end else begin
      s_now_q  <= s_now_d;
      s_last_q <= s_last_d;
      cnt_q    <= cnt_d;
    end
  end

  // Threshold crossing on the selected slope, then mode-dependent trigger.
  always_comb begin
    level_evt_c = 1'b0;
    trig_c      = 1'b0;
    if (rising) level_evt_c = (s_last_q < level_th) && (s_now_q >= level_th);
    else        level_evt_c = (s_last_q >= level_th) && (s_now_q < level_th);
    case (trig_mode)
      TM_MANUAL:     trig_c = 1'b0;
      TM_TIME:       trig_c = (cnt_q == time_th);
      TM_LEVEL:      trig_c = level_evt_c;
      TM_TIME_LEVEL: trig_c = level_evt_c && (cnt_q >= time_th);
      default:       trig_c = 1'b0;
    endcase
  end

  assign s_now = s_now_q;

endmodule : lock_trig_det

// File: rtl/lock_sequencer.sv
// Lock sequencer: arms a trigger search, locks the PID chain, watches for loss of lock.
// Optional build macro LOCK_SEQUENCER_RELOCK_EN: LOST re-arms automatically while arm=1
// and counts those relock attempts in relock_cnt.
module lock_sequencer
  import lock_seq_pkg::*;
#(
  parameter int unsigned DW   = 14,
  parameter int unsigned NPID = 2,
  parameter int unsigned TW   = 32
) (
  input logic             clk,
  input logic             rst,
  lock_sequencer_if.slave bus
);

  state_e               state_q, state_d;
  logic                 lock_trig_q, lock_trig_d;
  logic                 lock_lost_q, lock_lost_d;
  logic [LOSS_W-1:0]    loss_cnt_q, loss_cnt_d;
  logic [LOSS_W-1:0]    loss_inc_c;
  logic signed [DW-1:0] s_now;
  logic                 trig_c;
  logic                 hold_c;
  logic                 out_win_c;
  logic [NPID:0]        en_c;
`ifdef LOCK_SEQUENCER_RELOCK_EN
  logic [RELOCK_W-1:0]  relock_cnt_q, relock_cnt_d;
`endif

  lock_trig_det #(.DW(DW), .TW(TW)) u_trig_det (
    .clk       (clk),
    .rst       (rst),
    .signal    (bus.signal),
    .ramp_trig (bus.ramp_trig),
    .trig_mode (bus.trig_mode),
    .rising    (bus.rising),
    .time_th   (bus.time_th),
    .level_th  (bus.level_th),
    .s_now     (s_now),
    .trig_c    (trig_c)
  );

  // Next-state, loss counter and status flag logic.
  always_comb begin
    state_d     = state_q;
    lock_lost_d = lock_lost_q;
    loss_cnt_d  = '0;
`ifdef LOCK_SEQUENCER_RELOCK_EN
    relock_cnt_d = relock_cnt_q;
`endif
    hold_c     = !bus.arm && !bus.lock_now;
    out_win_c  = (s_now < bus.loss_lo) || (s_now > bus.loss_hi);
    loss_inc_c = (loss_cnt_q == {LOSS_W{1'b1}}) ? loss_cnt_q : loss_cnt_q + LOSS_W'(1);
    if (state_q == ST_LOCKED && out_win_c) loss_cnt_d = loss_inc_c;

    case (state_q)
      ST_IDLE: begin
        if (bus.lock_now) state_d = ST_LOCKED;
        else if (bus.arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (hold_c)                        state_d = ST_IDLE;
        else if (bus.lock_now || trig_c)   state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (hold_c) state_d = ST_IDLE;
        else if (bus.loss_cycles != '0 && out_win_c && loss_inc_c >= bus.loss_cycles)
          state_d = ST_LOST;
      end
      ST_LOST: begin
        if (hold_c) state_d = ST_IDLE;
`ifdef LOCK_SEQUENCER_RELOCK_EN
        else if (bus.arm) begin
          state_d = ST_ARMED;
          if (relock_cnt_q != {RELOCK_W{1'b1}}) relock_cnt_d = relock_cnt_q + RELOCK_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    lock_trig_d = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
    if (state_d == ST_LOST && state_q != ST_LOST)      lock_lost_d = 1'b1;
    else if (state_d == ST_IDLE && state_q != ST_IDLE) lock_lost_d = 1'b0;
  end

  // State and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_trig_q <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
`ifdef LOCK_SEQUENCER_RELOCK_EN
      relock_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lock_trig_q <= lock_trig_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
`ifdef LOCK_SEQUENCER_RELOCK_EN
      relock_cnt_q <= relock_cnt_d;
`endif
    end
  end

  // Enables follow the state register directly so reset takes effect without a clock.
  always_comb begin
    en_c = (state_q == ST_LOCKED) ? bus.lock_en : bus.idle_en;
  end

  assign {bus.ramp_enable, bus.pid_enable} = en_c;
  assign bus.lock_trig = lock_trig_q;
  assign bus.locked    = (state_q == ST_LOCKED);
  assign bus.lock_lost = lock_lost_q;
  assign bus.state     = state_q;
`ifdef LOCK_SEQUENCER_RELOCK_EN
  assign bus.relock_cnt = relock_cnt_q;
`else
  assign bus.relock_cnt = '0;
`endif

endmodule : lock_sequencer

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer (default parameters).
module tb_lock_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  localparam logic [2:0] IDLE_EN = 3'b001;
  localparam logic [2:0] LOCK_EN = 3'b110;

  lock_sequencer_if #(.DW(14), .NPID(2), .TW(32)) bus ();

  lock_sequencer #(.DW(14), .NPID(2), .TW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL rst_state got %0b exp 00", bus.state); end
    checks++; if ({bus.ramp_enable, bus.pid_enable} !== IDLE_EN) begin errors++; $display("FAIL rst_en got %b exp %b", {bus.ramp_enable, bus.pid_enable}, IDLE_EN); end
    checks++; if (bus.lock_trig !== 1'b0 || bus.lock_lost !== 1'b0 || bus.locked !== 1'b0) begin errors++; $display("FAIL rst_flags got trig=%b lost=%b locked=%b exp 0 0 0", bus.lock_trig, bus.lock_lost, bus.locked); end
    checks++; if (bus.relock_cnt !== 8'd0) begin errors++; $display("FAIL rst_relock got %0d exp 0", bus.relock_cnt); end
    rst = 1'b0;
    tick();
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL post_rst_state got %0b exp 00", bus.state); end
  endtask

  task automatic test_level_trigger();
    bus.trig_mode = 2'b10;
    bus.rising    = 1'b1;
    bus.level_th  = 14'sd100;
    bus.signal    = 14'sd99;
    bus.arm       = 1'b1;
    tick();
    tick();
    checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL lvl_armed got %0b exp 01", bus.state); end
    bus.signal = 14'sd100;
    tick();
    checks++; if (bus.state !== 2'b01 || bus.lock_trig !== 1'b0) begin errors++; $display("FAIL lvl_early got state=%0b trig=%b exp 01 0", bus.state, bus.lock_trig); end
    tick();
    checks++; if (bus.state !== 2'b10 || bus.lock_trig !== 1'b1 || bus.locked !== 1'b1) begin errors++; $display("FAIL lvl_lock got state=%0b trig=%b locked=%b exp 10 1 1", bus.state, bus.lock_trig, bus.locked); end
    checks++; if ({bus.ramp_enable, bus.pid_enable} !== LOCK_EN) begin errors++; $display("FAIL lvl_en got %b exp %b", {bus.ramp_enable, bus.pid_enable}, LOCK_EN); end
    tick();
    checks++; if (bus.lock_trig !== 1'b0 || bus.state !== 2'b10) begin errors++; $display("FAIL lvl_pulse got trig=%b state=%0b exp 0 10", bus.lock_trig, bus.state); end
  endtask

  task automatic test_time_level();
    bus.arm = 1'b0;
    tick();
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL tl_idle got %0b exp 00", bus.state); end
    bus.trig_mode = 2'b11;
    bus.time_th   = 32'd50;
    bus.signal    = 14'sd0;
    tick();
    tick();
    bus.arm       = 1'b1;
    bus.ramp_trig = 1'b1;
    tick();                      // cnt = 0
    bus.ramp_trig = 1'b0;
    repeat (29) tick();          // cnt = 29
    bus.signal = 14'sd100;
    tick();                      // cnt = 30, event live
    tick();                      // cnt = 31
    checks++; if (bus.state !== 2'b01 || bus.lock_trig !== 1'b0) begin errors++; $display("FAIL tl_at30 got state=%0b trig=%b exp 01 0", bus.state, bus.lock_trig); end
    bus.signal = 14'sd0;
    tick();                      // cnt = 32
    tick();                      // cnt = 33
    repeat (26) tick();          // cnt = 59
    bus.signal = 14'sd100;
    tick();                      // cnt = 60, event live
    tick();
    checks++; if (bus.state !== 2'b10 || bus.lock_trig !== 1'b1) begin errors++; $display("FAIL tl_at60 got state=%0b trig=%b exp 10 1", bus.state, bus.lock_trig); end
  endtask

  task automatic test_loss();
    bus.signal = 14'sd0;
    tick();
    tick();
    bus.loss_cycles = 16'd3;
    bus.signal = 14'sd20;
    tick();
    tick();
    bus.signal = 14'sd0;
    tick();
    checks++; if (bus.state !== 2'b10 || bus.lock_lost !== 1'b0) begin errors++; $display("FAIL loss_short got state=%0b lost=%b exp 10 0", bus.state, bus.lock_lost); end
    tick();
    bus.signal = 14'sd20;
    tick();
    tick();
    tick();
    checks++; if (bus.state !== 2'b10 || bus.lock_lost !== 1'b0) begin errors++; $display("FAIL loss_pre got state=%0b lost=%b exp 10 0", bus.state, bus.lock_lost); end
    tick();
    checks++; if (bus.state !== 2'b11 || bus.lock_lost !== 1'b1 || bus.locked !== 1'b0) begin errors++; $display("FAIL loss_lost got state=%0b lost=%b locked=%b exp 11 1 0", bus.state, bus.lock_lost, bus.locked); end
    checks++; if ({bus.ramp_enable, bus.pid_enable} !== IDLE_EN) begin errors++; $display("FAIL loss_en got %b exp %b", {bus.ramp_enable, bus.pid_enable}, IDLE_EN); end
  endtask

  task automatic test_relock();
    tick();
`ifdef LOCK_SEQUENCER_RELOCK_EN
    checks++; if (bus.state !== 2'b01 || bus.relock_cnt !== 8'd1) begin errors++; $display("FAIL relock got state=%0b cnt=%0d exp 01 1", bus.state, bus.relock_cnt); end
`else
    checks++; if (bus.state !== 2'b11 || bus.relock_cnt !== 8'd0) begin errors++; $display("FAIL no_relock got state=%0b cnt=%0d exp 11 0", bus.state, bus.relock_cnt); end
`endif
    checks++; if (bus.lock_lost !== 1'b1) begin errors++; $display("FAIL relock_sticky got %b exp 1", bus.lock_lost); end
    bus.loss_cycles = 16'd0;
    bus.signal = 14'sd0;
    bus.arm = 1'b0;
    tick();
    checks++; if (bus.state !== 2'b00 || bus.lock_lost !== 1'b0) begin errors++; $display("FAIL relock_idle got state=%0b lost=%b exp 00 0", bus.state, bus.lock_lost); end
  endtask

  task automatic test_arm_drop();
    bus.trig_mode = 2'b01;
    bus.time_th   = 32'd5;
    bus.arm       = 1'b1;
    bus.ramp_trig = 1'b1;
    tick();                      // cnt = 0
    bus.ramp_trig = 1'b0;
    repeat (5) tick();           // cnt = 5, time trigger live
    checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL drop_armed got %0b exp 01", bus.state); end
    bus.arm = 1'b0;
    tick();
    checks++; if (bus.state !== 2'b00 || bus.lock_trig !== 1'b0) begin errors++; $display("FAIL drop_idle got state=%0b trig=%b exp 00 0", bus.state, bus.lock_trig); end
    bus.trig_mode = 2'b00;
    bus.arm = 1'b1;
    tick();
    checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL manual_armed got %0b exp 01", bus.state); end
    bus.lock_now = 1'b1;
    tick();
    checks++; if (bus.state !== 2'b10 || bus.lock_trig !== 1'b1) begin errors++; $display("FAIL manual_lock got state=%0b trig=%b exp 10 1", bus.state, bus.lock_trig); end
    bus.lock_now = 1'b0;
    tick();
    checks++; if (bus.state !== 2'b10 || bus.lock_trig !== 1'b0) begin errors++; $display("FAIL manual_hold got state=%0b trig=%b exp 10 0", bus.state, bus.lock_trig); end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({bus.ramp_enable, bus.pid_enable} !== IDLE_EN) begin errors++; $display("FAIL arst_en got %b exp %b", {bus.ramp_enable, bus.pid_enable}, IDLE_EN); end
    checks++; if (bus.state !== 2'b00 || bus.locked !== 1'b0) begin errors++; $display("FAIL arst_state got state=%0b locked=%b exp 00 0", bus.state, bus.locked); end
    tick();
    rst = 1'b0;
    bus.arm = 1'b0;
    tick();
    checks++; if (bus.state !== 2'b00 || bus.relock_cnt !== 8'd0) begin errors++; $display("FAIL arst_after got state=%0b cnt=%0d exp 00 0", bus.state, bus.relock_cnt); end
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    checks = 0;
    errors = 0;
    bus.arm         = 1'b0;
    bus.lock_now    = 1'b0;
    bus.trig_mode   = 2'b00;
    bus.rising      = 1'b1;
    bus.time_th     = 32'd0;
    bus.level_th    = 14'sd0;
    bus.loss_lo     = -14'sd10;
    bus.loss_hi     = 14'sd10;
    bus.loss_cycles = 16'd0;
    bus.idle_en     = IDLE_EN;
    bus.lock_en     = LOCK_EN;
    bus.signal      = 14'sd0;
    bus.ramp_trig   = 1'b0;
    repeat (2) tick();
    test_reset();
    test_level_trigger();
    test_time_level();
    test_loss();
    test_relock();
    test_arm_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_lock_sequencer
